// File: rtl/debug_ctrl_dump.sv
// rtl/debug_ctrl_dump.sv - debug controller: run/step/halt commands and LSB-first UART state dump
module debug_ctrl_dump #(
  parameter int BYTE      = 8,
  parameter int WORD      = 32,
  parameter int ADDR      = 5,
  parameter int NREGS     = 32,
  parameter int MEM_DEPTH = 32,
  parameter logic [BYTE-1:0] CMD_RUN  = BYTE'(4),
  parameter logic [BYTE-1:0] CMD_HALT = BYTE'(5),
  parameter logic [BYTE-1:0] CMD_STEP = BYTE'(6),
  parameter logic [BYTE-1:0] CMD_DUMP = BYTE'(7)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [BYTE-1:0] i_rx_data,
  input  logic            i_rx_valid,
  input  logic            i_tx_ready,
  output logic [BYTE-1:0] o_tx_data,
  output logic            o_tx_start,
  input  logic            i_halt,
  input  logic [WORD-1:0] i_pc,
  output logic            o_cpu_enable,
  output logic            o_rd_sel,
  output logic [ADDR-1:0] o_rd_addr,
  input  logic [WORD-1:0] i_rd_data,
  output logic            o_busy,
  output logic            o_done
);

  localparam int NBYTES = WORD / BYTE;
  localparam int NIDX   = 1 + NREGS + MEM_DEPTH;
  localparam int IDXW   = $clog2(NIDX + 1);
  localparam int BCW    = $clog2(NBYTES + 1);
  // Address arithmetic is done at least ADDR bits wide so the final cast only truncates.
  localparam int CW     = (IDXW > ADDR) ? IDXW : ADDR;

  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NREGS + MEM_DEPTH);
  localparam logic [IDXW-1:0] IDX_NREGS = IDXW'(NREGS);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, RUN, STEP, D_REQ, D_WAIT, D_SEND, D_NEXT} state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic [BCW-1:0]    r_byte;
  logic [WORD-1:0]   r_shift;
  logic [BYTE-1:0]   r_tx_data;
  logic              r_tx_start;
  logic              r_cpu_enable;
  logic              r_rd_sel;
  logic [ADDR-1:0]   r_rd_addr;
  logic              r_busy;
  logic              r_done;

  state_t            w_next;
  logic [IDXW-1:0]   w_idx_nxt;
  logic              w_set_done;
  logic              w_fire;
  logic              w_rd_sel;
  logic [CW-1:0]     w_idx_ext;
  logic [ADDR-1:0]   w_rd_addr;

  // Next-state decode, byte-send decision and read-address generation for the upcoming index.
  always_comb begin
    w_next     = r_state;
    w_idx_nxt  = r_idx;
    w_set_done = 1'b0;
    w_fire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_RUN && !r_done)       w_next = RUN;
          else if (i_rx_data == CMD_STEP && !r_done) w_next = STEP;
          else if (i_rx_data == CMD_DUMP)            w_next = D_REQ;
        end
      end
      RUN: begin
        // A retired halt beats a simultaneous halt command so o_done is never missed.
        if (i_halt) begin
          w_set_done = 1'b1;
          w_next     = D_REQ;
        end else if (i_rx_valid && i_rx_data == CMD_HALT) begin
          w_next = D_REQ;
        end
      end
      STEP: begin
        w_set_done = i_halt;
        w_next     = D_REQ;
      end
      D_REQ:  w_next = D_WAIT;
      D_WAIT: w_next = D_SEND;
      D_SEND: begin
        // While o_tx_start is high the transmitter has not yet had a chance to drop ready.
        if (i_tx_ready && !r_tx_start) begin
          w_fire = 1'b1;
          if (r_byte == LAST_BYTE) w_next = D_NEXT;
        end
      end
      D_NEXT: begin
        if (r_idx == IDX_LAST) begin
          w_next    = IDLE;
          w_idx_nxt = '0;
        end else begin
          w_next    = D_REQ;
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase

    // Index 0 is the PC, then NREGS registers, then the memory words.
    w_idx_ext = CW'(w_idx_nxt);
    w_rd_sel  = (w_idx_nxt > IDX_NREGS);
    if (w_rd_sel)               w_rd_addr = ADDR'(w_idx_ext - CW'(NREGS + 1));
    else if (w_idx_nxt == '0)   w_rd_addr = '0;
    else                        w_rd_addr = ADDR'(w_idx_ext - CW'(1));
  end

  // State register and all registered outputs; reset overrides any dump in progress.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_byte       <= '0;
      r_shift      <= '0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_cpu_enable <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_rd_addr    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_idx        <= w_idx_nxt;
      r_cpu_enable <= (w_next == RUN) || (w_next == STEP);
      r_busy       <= (w_next != IDLE);
      r_rd_sel     <= w_rd_sel;
      r_rd_addr    <= w_rd_addr;
      r_tx_start   <= w_fire;
      if (w_set_done) r_done <= 1'b1;
      if (r_state == D_WAIT) begin
        r_shift <= (r_idx == '0) ? i_pc : i_rd_data;
        r_byte  <= '0;
      end else if (w_fire) begin
        r_tx_data <= r_shift[BYTE-1:0];
        r_shift   <= r_shift >> BYTE;
        r_byte    <= r_byte + 1'b1;
      end
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = r_tx_start;
  assign o_cpu_enable = r_cpu_enable;
  assign o_rd_sel     = r_rd_sel;
  assign o_rd_addr    = r_rd_addr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
